// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences decode loads/stores onto a req/ack word bus.
// `define MEM_TIMEOUT_EN to abort transfers stuck for TIMEOUT_CYCLES.
module mem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_access_size,
    input  logic              mem_access_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data_hi,
    input  logic [31:0]       st_data_lo,
    input  logic [4:0]        rd,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              done,
    output logic              align_trap,
    output logic              bus_err
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int CNT_W =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              done_q, done_d;
    logic              align_trap_q, align_trap_d;
    logic              bus_err_q, bus_err_d;

    logic              is_ld_q, is_ld_d;
    logic [1:0]        size_q, size_d;
    logic              sgn_q, sgn_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       st_lo_q, st_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    function automatic logic [3:0] lane_be(input logic [1:0] sz,
                                           input logic [1:0] off);
        unique case (sz)
            SZ_B:    lane_be = 4'b1000 >> off;
            SZ_H:    lane_be = off[1] ? 4'b0011 : 4'b1100;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    // Big-endian: byte offset 0 lives in bits 31:24
    function automatic logic [31:0] lane_wdata(input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic [31:0] d);
        unique case (sz)
            SZ_B:    lane_wdata = {24'b0, d[7:0]} << {~off, 3'b000};
            SZ_H:    lane_wdata = off[1] ? {16'b0, d[15:0]}
                                         : {d[15:0], 16'b0};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0]  sz,
                                             input logic        sgn,
                                             input logic [1:0]  off,
                                             input logic [31:0] r);
        logic [31:0] sh;
        logic [15:0] hw;
        sh = r >> {~off, 3'b000};
        hw = off[1] ? r[15:0] : r[31:16];
        unique case (sz)
            SZ_B:    load_ext = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_H:    load_ext = {{16{sgn & hw[15]}}, hw};
            default: load_ext = r;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz,
                                        input logic [2:0] a,
                                        input logic       ld,
                                        input logic       rd0);
        unique case (sz)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = a[0];
            SZ_W:    misaligned = |a[1:0];
            default: misaligned = (|a) | (ld & rd0);
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        done_d       = 1'b0;
        align_trap_d = 1'b0;
        bus_err_d    = 1'b0;
        is_ld_d      = is_ld_q;
        size_d       = size_q;
        sgn_d        = sgn_q;
        off_d        = off_q;
        rd_d         = rd_q;
        st_lo_d      = st_lo_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    is_ld_d = mem_read;
                    size_d  = mem_access_size;
                    sgn_d   = mem_access_signed;
                    off_d   = addr[1:0];
                    rd_d    = rd;
                    st_lo_d = st_data_lo;
                    if (mem_read == mem_write) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else if (misaligned(mem_access_size, addr[2:0],
                                            mem_read, rd[0])) begin
                        align_trap_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        state_d     = ACC1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = lane_be(mem_access_size, addr[1:0]);
                        mem_wdata_d = lane_wdata(mem_access_size, addr[1:0],
                                                 st_data_hi);
                        cnt_d       = '0;
                    end
                end
            end
            ACC1, ACC2: begin
                if (mem_ack) begin
                    if (is_ld_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = (state_q == ACC2) ? (rd_q | 5'd1) : rd_q;
                        wb_data_d  = load_ext(size_q, sgn_q, off_q, mem_rdata);
                    end
                    if (state_q == ACC1 && size_q == SZ_D) begin
                        state_d     = ACC2;
                        mem_addr_d  = mem_addr_q + ADDR_W'(4);
                        mem_wdata_d = st_lo_q;
                        cnt_d       = '0;
                    end else begin
                        state_d   = FIN;
                        mem_req_d = 1'b0;
                        done_d    = 1'b1;
                    end
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == TO_VAL) begin
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            done_q       <= 1'b0;
            align_trap_q <= 1'b0;
            bus_err_q    <= 1'b0;
            is_ld_q      <= 1'b0;
            size_q       <= '0;
            sgn_q        <= 1'b0;
            off_q        <= '0;
            rd_q         <= '0;
            st_lo_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            done_q       <= done_d;
            align_trap_q <= align_trap_d;
            bus_err_q    <= bus_err_d;
            is_ld_q      <= is_ld_d;
            size_q       <= size_d;
            sgn_q        <= sgn_d;
            off_q        <= off_d;
            rd_q         <= rd_d;
            st_lo_q      <= st_lo_d;
            cnt_q        <= cnt_d;
        end
    end

    assign busy       = busy_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign done       = done_q;
    assign align_trap = align_trap_q;
    assign bus_err    = bus_err_q;

endmodule
